// File: rtl/wl_pulse_sequencer_if.sv
// Row-access request channel between the array controller and wl_pulse_sequencer.
// Optional broadcast field req_all exists only when WL_BROADCAST_EN is defined.
interface wl_pulse_sequencer_if #(
    parameter int ADDR_W  = 8,
    parameter int PULSE_W = 4,
    parameter int BURST_W = 4
);
    logic               req_valid;
    logic               req_ready;
    logic [ADDR_W-1:0]  req_addr;
    logic [PULSE_W-1:0] req_pulse;
    logic [BURST_W-1:0] req_burst;
`ifdef WL_BROADCAST_EN
    logic               req_all;
`endif

    modport master (
        output req_valid,
        output req_addr,
        output req_pulse,
        output req_burst,
`ifdef WL_BROADCAST_EN
        output req_all,
`endif
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_pulse,
        input  req_burst,
`ifdef WL_BROADCAST_EN
        input  req_all,
`endif
        output req_ready
    );
endinterface

// File: rtl/wl_pulse_sequencer.sv
// Wordline pulse sequencer: decodes a start row, pulses it, then bursts through rows with a gap cycle.
// Optional macro WL_BROADCAST_EN adds req_all, which drives every wordline for a single pulse.
module wl_pulse_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int NUM_WL  = 162,
    parameter int PULSE_W = 4,
    parameter int BURST_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    wl_pulse_sequencer_if.slave   req,
    input  logic                  abort,
    input  logic                  en,
    output logic [NUM_WL-1:0]     wl_out,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_GAP    = 2'd1;
    localparam logic [1:0] S_ASSERT = 2'd2;

    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(NUM_WL - 1);

    logic [1:0]         state;
    logic [ADDR_W-1:0]  row;
    logic [PULSE_W-1:0] pulse_len;
    logic [PULSE_W-1:0] cnt;
    logic [BURST_W-1:0] rows_left;
    logic [NUM_WL-1:0]  wl_reg;
    logic [NUM_WL-1:0]  wl_next;
    logic               all_r;
    logic               req_all_in;
    logic               row_oob;
    logic [ADDR_W-1:0]  row_inc;

`ifdef WL_BROADCAST_EN
    assign req_all_in = req.req_all;
`else
    assign req_all_in = 1'b0;
`endif

    assign row_oob = (row > LAST_ROW);
    // An out-of-range start row also restarts at row 0, so only the start row can be out of range.
    assign row_inc = (row >= LAST_ROW) ? '0 : row + ADDR_W'(1);

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        wl_next = '0;
        for (int i = 0; i < NUM_WL; i++) begin
            wl_next[i] = all_r | (row == ADDR_W'(i));
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            row       <= '0;
            pulse_len <= '0;
            cnt       <= '0;
            rows_left <= '0;
            wl_reg    <= '0;
            all_r     <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // abort is ignored here; a valid request is still accepted
                    if (req.req_valid) begin
                        state     <= S_GAP;
                        row       <= req.req_addr;
                        pulse_len <= req.req_pulse;
                        rows_left <= req_all_in ? '0 : req.req_burst;
                        all_r     <= req_all_in;
                        err       <= 1'b0;
                    end
                end
                S_GAP: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else begin
                        state  <= S_ASSERT;
                        cnt    <= (pulse_len == '0) ? PULSE_W'(1) : pulse_len;
                        wl_reg <= wl_next;
                        if (row_oob && !all_r) begin
                            err <= 1'b1;
                        end
                    end
                end
                S_ASSERT: begin
                    if (abort) begin
                        state  <= S_IDLE;
                        wl_reg <= '0;
                    end else if (cnt == PULSE_W'(1)) begin
                        wl_reg <= '0;
                        if (rows_left != '0) begin
                            rows_left <= rows_left - BURST_W'(1);
                            row       <= row_inc;
                            state     <= S_GAP;
                        end else begin
                            state <= S_IDLE;
                            done  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - PULSE_W'(1);
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    wl_reg <= '0;
                end
            endcase
        end
    end

    // Gating after the register lets en blank the drivers without disturbing the sequence.
    assign wl_out        = en ? wl_reg : '0;
    assign busy          = (state != S_IDLE);
    assign req.req_ready = (state == S_IDLE);

endmodule
